des_perm_pipe: RTL and testbench

- Streaming, pipelined DES permutation engine.
- Applies either the initial permutation (IP) or its inverse, the final permutation (FP = IP^-1), to LANES independent 64-bit blocks per beat.
- Uses a valid/ready handshake with registered stages.
- Sits between the block-input interface and the round datapath (IP mode), and between the round datapath and the output interface (FP mode). One instance can be shared by time-multiplexing the mode.

---
 rtl/des_pkg.sv | 39 +++
 rtl/des_perm_lane.sv | 15 +
 rtl/des_perm_pipe.sv | 94 +++++++++
 tb/tb_des_perm_pipe.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// des_pkg: shared DES permutation constants.
//   BLK_W             block width in bits
//   MODE_IP / MODE_FP mode encodings carried with each beat
//   IP_TABLE/FP_TABLE 1-based source bit index for each output bit (bit 1 = MSB)
//   permute()         applies IP or FP to one block
package des_pkg;
  localparam int BLK_W = 64;
  localparam logic MODE_IP = 1'b0;
  localparam logic MODE_FP = 1'b1;
  localparam int IP_TABLE [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };
  localparam int FP_TABLE [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41, 9, 49, 17, 57, 25
  };
  // Output bits are shifted in MSB-first, so table entry i lands on DES bit i+1.
  // DES bit n lives at vector index BLK_W-n.
  function automatic logic [BLK_W-1:0] permute(input logic [BLK_W-1:0] blk, input logic mode);
    logic [BLK_W-1:0] p;
    p = '0;
    for (int i = 0; i < BLK_W; i++)
      p = {p[BLK_W-2:0], blk[6'(BLK_W - (mode == MODE_FP ? FP_TABLE[i] : IP_TABLE[i]))]};
    return p;
  endfunction
endpackage

// File: rtl/des_perm_lane.sv
// des_perm_lane: combinational single-block DES IP/FP permutation with keep zeroing.
//   mode    0 = IP, 1 = FP
//   keep    block present; when 0 the output is forced to zero
//   blk_in  input block (bit 1 = MSB)
//   blk_out permuted block
module des_perm_lane
  import des_pkg::*;
(
  input  logic             mode,
  input  logic             keep,
  input  logic [BLK_W-1:0] blk_in,
  output logic [BLK_W-1:0] blk_out
);
  always_comb blk_out = keep ? permute(blk_in, mode) : '0;
endmodule

// File: rtl/des_perm_pipe.sv
// des_perm_pipe: streaming pipelined DES IP/FP permutation over LANES blocks per beat.
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_mode, in_keep, in_text sampled with the beat
//   out_valid/out_ready   output handshake; out_mode, out_keep, out_text carried with the beat
//   busy                  any stage holds a valid beat
//   Optional (DES_PERM_CNT_EN): cnt_clear input, blk_count[31:0] kept-block counter output
module des_perm_pipe
  import des_pkg::*;
#(
  parameter int LANES       = 1,
  parameter int PIPE_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_mode,
  input  logic [LANES-1:0]       in_keep,
  input  logic [BLK_W*LANES-1:0] in_text,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_mode,
  output logic [LANES-1:0]       out_keep,
  output logic [BLK_W*LANES-1:0] out_text,
`ifdef DES_PERM_CNT_EN
  input  logic                   cnt_clear,
  output logic [31:0]            blk_count,
`endif
  output logic                   busy
);
  localparam int DW = BLK_W * LANES;
  logic [DW-1:0] perm_text;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    des_perm_lane u_lane (
      .mode   (in_mode),
      .keep   (in_keep[k]),
      .blk_in (in_text[BLK_W*k +: BLK_W]),
      .blk_out(perm_text[BLK_W*k +: BLK_W])
    );
  end
  logic [PIPE_STAGES-1:0] vld_q, vld_d, mode_q, mode_d, rdy;
  logic [LANES-1:0] keep_q [PIPE_STAGES];
  logic [LANES-1:0] keep_d [PIPE_STAGES];
  logic [DW-1:0] text_q [PIPE_STAGES];
  logic [DW-1:0] text_d [PIPE_STAGES];
  // Stage s can load unless it and every stage after it is full and the sink stalls;
  // written in closed form so the ready chain never reads itself.
  always_comb begin
    rdy = '0;
    for (int s = 0; s < PIPE_STAGES; s++) rdy[s] = out_ready | (|((~vld_q) >> s));
  end
  always_comb begin
    vld_d = vld_q;
    mode_d = mode_q;
    keep_d = keep_q;
    text_d = text_q;
    for (int s = 0; s < PIPE_STAGES; s++)
      if (rdy[s]) begin
        vld_d[s] = s == 0 ? in_valid : vld_q[s == 0 ? 0 : s-1];
        if (s == 0 ? in_valid : vld_q[s == 0 ? 0 : s-1]) begin
          mode_d[s] = s == 0 ? in_mode : mode_q[s == 0 ? 0 : s-1];
          keep_d[s] = s == 0 ? in_keep : keep_q[s == 0 ? 0 : s-1];
          text_d[s] = s == 0 ? perm_text : text_q[s == 0 ? 0 : s-1];
        end
      end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      vld_q <= '0;
      mode_q <= '0;
      keep_q <= '{default: '0};
      text_q <= '{default: '0};
    end else begin
      vld_q <= vld_d;
      mode_q <= mode_d;
      keep_q <= keep_d;
      text_q <= text_d;
    end
  assign in_ready = rdy[0];
  assign out_valid = vld_q[PIPE_STAGES-1];
  assign out_mode = mode_q[PIPE_STAGES-1];
  assign out_keep = keep_q[PIPE_STAGES-1];
  assign out_text = text_q[PIPE_STAGES-1];
  assign busy = |vld_q;
`ifdef DES_PERM_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  // Clear wins over a same-cycle increment; the sum wraps naturally at 2^32.
  always_comb cnt_d = cnt_clear ? '0 : (out_valid & out_ready) ? cnt_q + 32'($countones(out_keep)) : cnt_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign blk_count = cnt_q;
`endif
endmodule

// File: tb/tb_des_perm_pipe.sv
module tb_des_perm_pipe;
  localparam int L = 4, P = 3, W = 64*L;
  logic clk = 0, reset_n = 1, in_valid = 0, in_mode = 0, out_ready = 1;
  logic in_ready, out_valid, out_mode, busy;
  logic [L-1:0] in_keep = '0, out_keep;
  logic [W-1:0] in_text = '0, out_text, cur_exp = '0;
`ifdef DES_PERM_CNT_EN
  logic cnt_clear = 0;
  logic [31:0] blk_count, cnt0;
`endif
  typedef struct {logic mode; logic [L-1:0] keep; logic [W-1:0] text; int acc;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic [W-1:0] got[$], orig[$];
  int total = 0, bad = 0, cyc = 0, bp_lo = -1, bp_hi = -2;
  bit check_lat = 0, collect = 0, stall_prev = 0, saw_block = 0, accepted = 0;
  logic [W+L:0] held;
  int ip_t [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
                    64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
                    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  int fp_t [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30,
                    37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                    34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam logic [63:0] PT = 64'h0123456789ABCDEF, CT = 64'hCC00CCFFF0AAF0AA;

  always #5 clk = ~clk;

  des_perm_pipe #(.LANES(L), .PIPE_STAGES(P)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_keep(in_keep), .in_text(in_text), .out_valid(out_valid), .out_ready(out_ready),
    .out_mode(out_mode), .out_keep(out_keep), .out_text(out_text),
`ifdef DES_PERM_CNT_EN
    .cnt_clear(cnt_clear), .blk_count(blk_count),
`endif
    .busy(busy));

  function automatic logic [63:0] ref_perm(logic [63:0] b, logic fp);
    logic [63:0] r;
    r = '0;
    for (int i = 1; i <= 64; i++) r[64-i] = b[64 - (fp ? fp_t[i-1] : ip_t[i-1])];
    return r;
  endfunction

  function automatic logic [W-1:0] ref_beat(logic m, logic [L-1:0] k, logic [W-1:0] t);
    logic [W-1:0] r;
    r = '0;
    for (int j = 0; j < L; j++) if (k[j]) r[64*j +: 64] = ref_perm(t[64*j +: 64], m);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int j = 0; j < W/32; j++) r[32*j +: 32] = $urandom();
    return r;
  endfunction

  task automatic chk(string tag, logic [511:0] obs, logic [511:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    out_ready = !(cyc >= bp_lo && cyc <= bp_hi);
    @(negedge clk);
    if (stall_prev) chk("stable", {out_mode, out_keep, out_text}, held);
    if (!in_ready) begin saw_block = 1; chk("full_occupancy", sb.size(), P); end
    if (out_valid && out_ready) begin
      chk("beat_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("beat", {out_mode, out_keep, out_text}, {e.mode, e.keep, e.text});
        if (check_lat) chk("latency", cyc - e.acc, P);
        if (collect) got.push_back(out_text);
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) sb.push_back('{in_mode, in_keep, cur_exp, cyc});
    stall_prev = out_valid && !out_ready;
    held = {out_mode, out_keep, out_text};
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(logic m, logic [L-1:0] k, logic [W-1:0] t, logic [W-1:0] x);
    int n;
    n = 0;
    in_valid = 1; in_mode = m; in_keep = k; in_text = t; cur_exp = x;
    do begin step(); n++; end while (!accepted && n < 100);
    if (!accepted) chk("accept_timeout", n, 0);
    in_valid = 0;
  endtask

  task automatic sendm(logic m, logic [L-1:0] k, logic [W-1:0] t);
    send(m, k, t, ref_beat(m, k, t));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin step(); n++; end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    logic [W-1:0] t;
    #1 reset_n = 0;
    #11;
    chk("rst_out", {out_valid, out_mode, out_keep, out_text, busy}, '0);
    @(negedge clk) reset_n = 1;
    #1 chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    // known-answer vectors with exact latency
    check_lat = 1;
    send(0, 4'b0001, {192'h0, PT}, {192'h0, CT});
    drain();
    send(1, 4'b0001, {192'h0, CT}, {192'h0, PT});
    drain();
`ifdef DES_PERM_CNT_EN
    cnt0 = blk_count;
`endif
    send(0, 4'b1010, {PT, PT, PT, PT}, {CT, 64'h0, CT, 64'h0});
    drain();
`ifdef DES_PERM_CNT_EN
    chk("cnt_plus2", blk_count, cnt0 + 2);
`endif
    send(0, 4'b0000, rnd(), '0);
    drain();
    // back-to-back mode changes, no bubble
    for (int i = 0; i < 6; i++) sendm(i[0], 4'b1111, rnd());
    drain();
    check_lat = 0;
    // backpressure window
    bp_lo = cyc + 5; bp_hi = cyc + 12;
    for (int i = 0; i < 20; i++) sendm($urandom_range(0, 1), 4'($urandom_range(0, 15)), rnd());
    drain();
    chk("in_ready_fell", saw_block, 1);
    // round trip: IP then FP must restore the originals
    collect = 1;
    for (int i = 0; i < 250; i++) begin t = rnd(); orig.push_back(t); sendm(0, 4'b1111, t); end
    drain();
    collect = 0;
    chk("rt_count", got.size(), 250);
    for (int i = 0; i < got.size(); i++) send(1, 4'b1111, got[i], orig[i]);
    drain();
    // reset with beats in flight
    sendm(0, 4'b1111, rnd());
    sendm(1, 4'b0110, rnd());
    chk("busy_inflight", busy, 1);
    #2 reset_n = 0;
    #1 chk("rst_mid", {out_valid, busy, out_keep, out_text}, '0);
    sb.delete();
    stall_prev = 0;
    @(negedge clk) reset_n = 1;
    @(posedge clk); #1;
    check_lat = 1;
    sendm(1, 4'b1111, rnd());
    drain();
    repeat (5) step();
    chk("idle_busy", busy, 0);
    check_lat = 0;
`ifdef DES_PERM_CNT_EN
    sendm(0, 4'b1111, rnd());
    repeat (P-1) step();
    cnt_clear = 1;
    step();
    cnt_clear = 0;
    chk("cnt_clear", blk_count, 0);
    drain();
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.cnt_q;
    sendm(0, 4'b0001, rnd());
    drain();
    chk("cnt_wrap", blk_count, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
